mul_seq_disp: RTL and testbench

- Sequential 3-bit x 3-bit unsigned shift-add multiplier, the multiply counterpart to the team's switch-driven divider.
- Operands come from board switches. A start pulse launches a 3-cycle calculation.
- The 6-bit product is held in a register and shown as two hex digits on the 8-digit multiplexed digital tube: active-low segments, active-low digit enables.

---
 rtl/mul_seq_disp_pkg.sv | 39 +++
 rtl/mul_seq_disp_if.sv | 26 ++
 rtl/mul_seq_disp_seg7_hex.sv | 11 +
 rtl/mul_seq_disp.sv | 124 ++++++++++++
 tb/tb_mul_seq_disp.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mul_seq_disp_pkg.sv
// Shared types and constants for the switch-driven multiplier and its display.
// The hex-to-segment table is common with the divider's display path.
package mul_seq_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] DIG_OFF = 8'hFF;
    localparam logic [7:0] DIG0_EN = 8'hFE;
    localparam logic [7:0] DIG1_EN = 8'hFD;

    // Active-low segments, bit7 is the decimal point and stays dark.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] seg;
        case (hex)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/mul_seq_disp_if.sv
// Switch/start inputs, status and product outputs, and tube drive of the multiplier.
// Handshake: start is a level sampled only in IDLE; done pulses one cycle when product updates.
interface mul_seq_disp_if #(parameter int WIDTH = 3);
    import mul_seq_disp_pkg::*;

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               start;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic [7:0]         c;
    logic [7:0]         en;
    state_t             state;

    modport master (
        output a, b, start,
        input  busy, done, product, c, en, state
    );

    modport slave (
        input  a, b, start,
        output busy, done, product, c, en, state
    );

endinterface

// File: rtl/mul_seq_disp_seg7_hex.sv
// Combinational hex digit to active-low 7-segment encoder.
module seg7_hex
    import mul_seq_disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [7:0] seg_o
);

    assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/mul_seq_disp.sv
// Sequential shift-add multiplier with the product shown as two hex digits
// on a multiplexed 8-digit tube.
module mul_seq_disp
    import mul_seq_disp_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter int          WIDTH    = 3
) (
    input  logic        clk,
    input  logic        rst,
    mul_seq_disp_if.slave bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic            done_q, done_d;

    logic [15:0]     scan_q, scan_d;
    logic            dsel_q, dsel_d;
    logic [7:0]      c_q, c_d;
    logic [7:0]      en_q, en_d;
    logic [3:0]      digit_hex;
    logic [7:0]      seg_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            scan_q    <= '0;
            dsel_q    <= 1'b0;
            c_q       <= DIG_OFF;
            en_q      <= DIG_OFF;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
            scan_q    <= scan_d;
            dsel_q    <= dsel_d;
            c_q       <= c_d;
            en_q      <= en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                product_d = acc_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit mux reads the live product register, so an update shows on the next edge.
    assign digit_hex = dsel_q ? {2'b00, product_q[5:4]} : product_q[3:0];

    seg7_hex u_seg7_hex (
        .hex_i (digit_hex),
        .seg_o (seg_w)
    );

    always_comb begin
        scan_d = scan_q + 16'd1;
        dsel_d = dsel_q;
        if (scan_q == SCAN_DIV - 16'd1) begin
            scan_d = '0;
            dsel_d = ~dsel_q;
        end
        c_d  = seg_w;
        en_d = dsel_q ? DIG1_EN : DIG0_EN;
    end

    assign bus.busy    = (state_q == CALC);
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.c       = c_q;
    assign bus.en      = en_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_mul_seq_disp.sv
// Randomized scoreboard bench for mul_seq_disp: launches are predicted from start/idle
// timing, products from plain a*b, and the tube from cycle counts since reset.
module tb_mul_seq_disp;

    localparam int SCAN = 4;

    logic clk;
    logic rst;

    mul_seq_disp_if bus_if ();

    mul_seq_disp #(.SCAN_DIV(16'd4), .WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    logic [5:0] exp_q[$];
    logic [7:0] seg_tab[16];

    int  edge_n    = 0;
    int  since_rst = 0;
    int  launch    = -100;
    int  next_free = 0;
    bit  rst_edge  = 1'b0;
    bit  seen_rst  = 1'b0;
    logic [5:0] model_prod = '0;
    logic [5:0] disp_prod  = '0;

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    // Reference model: which edges launch an operation and what it must produce.
    always @(posedge clk) begin
        logic [5:0] p;
        edge_n++;
        rst_edge = rst;
        if (rst) begin
            seen_rst = 1'b1;
            exp_q.delete();
            launch    = -100;
            next_free = edge_n + 1;
            since_rst = 0;
        end else begin
            since_rst++;
            if (edge_n >= next_free && bus_if.start === 1'b1) begin
                p = {3'b000, bus_if.a} * {3'b000, bus_if.b};
                exp_q.push_back(p);
                launch    = edge_n;
                next_free = edge_n + 5;
            end
        end
    end

    // Monitor: compare on the falling edge what the previous rising edge produced.
    always @(negedge clk) begin
        logic [5:0] got;
        logic [7:0] exp_en;
        logic [3:0] hx;
        if (seen_rst) begin
            if (rst_edge) begin
                check("rst_busy", {7'b0, bus_if.busy}, 8'h00);
                check("rst_done", {7'b0, bus_if.done}, 8'h00);
                check("rst_product", {2'b00, bus_if.product}, 8'h00);
                check("rst_c", bus_if.c, 8'hFF);
                check("rst_en", bus_if.en, 8'hFF);
                model_prod = '0;
                disp_prod  = '0;
            end else begin
                check("busy", {7'b0, bus_if.busy},
                      {7'b0, (edge_n >= launch && edge_n <= launch + 2)});
                check("done", {7'b0, bus_if.done}, {7'b0, (edge_n == launch + 4)});
                if (bus_if.done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", 8'h01, 8'h00);
                    end else begin
                        got = exp_q.pop_front();
                        check("product_on_done", {2'b00, bus_if.product}, {2'b00, got});
                        model_prod = got;
                    end
                end
                check("product_held", {2'b00, bus_if.product}, {2'b00, model_prod});
                exp_en = (((since_rst - 1) / SCAN) % 2 == 1) ? 8'hFD : 8'hFE;
                hx = (exp_en == 8'hFE) ? disp_prod[3:0] : {2'b00, disp_prod[5:4]};
                check("en", bus_if.en, exp_en);
                check("c", bus_if.c, seg_tab[hx]);
                disp_prod = model_prod;
            end
        end
    end

    // driver tasks
    task automatic drive(input logic [2:0] a, input logic [2:0] b,
                         input logic s, input logic r);
        @(posedge clk);
        #1;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.start = s;
        rst          = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(bus_if.a, bus_if.b, 1'b0, 1'b0);
    endtask

    task automatic op(input logic [2:0] a, input logic [2:0] b);
        drive(a, b, 1'b1, 1'b0);
        drive($urandom_range(0, 7), $urandom_range(0, 7), 1'b0, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        bus_if.a     = '0;
        bus_if.b     = '0;
        bus_if.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        drive(3'd0, 3'd0, 1'b0, 1'b1);
        idle(3);

        op(3'd7, 3'd7);
        idle(12);
        op(3'd5, 3'd3);
        idle(10);
        op(3'd0, 3'd6);
        idle(6);

        op(3'd6, 3'd5);
        drive(3'd1, 3'd1, 1'b1, 1'b0);
        idle(6);

        drive(3'd7, 3'd6, 1'b1, 1'b0);
        drive(3'd7, 3'd6, 1'b0, 1'b0);
        drive(3'd7, 3'd6, 1'b0, 1'b1);
        idle(6);
        op(3'd7, 3'd6);
        idle(6);

        for (int i = 0; i < 12; i++) drive(3'd3, 3'd2, 1'b1, 1'b0);
        idle(8);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 80) == 0));
        end
        idle(10);

        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
